// File: rtl/rx_frame_fifo_if.sv
// rtl/rx_frame_fifo_if.sv - receive-side frame buffer bus (writer/reader/status signals)
// Rx_GoodCnt/Rx_BadCnt exist only when RX_FRAME_FIFO_STATS_EN is defined.
interface rx_frame_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int SIZE_W = $clog2(DEPTH + 1)
);
    logic [DATA_W-1:0] Rx_Data;
    logic              Rx_WrBuff;
    logic              Rx_EoF;
    logic              Rx_AbortSignal;
    logic              Rx_FrameError;
    logic              Rx_FCSen;
    logic              Rx_RdBuff;
    logic              Rx_Drop;
    logic [DATA_W-1:0] Rx_DataBuffOut;
    logic              Rx_Ready;
    logic [SIZE_W-1:0] Rx_FrameSize;
    logic              Rx_Overflow;
`ifdef RX_FRAME_FIFO_STATS_EN
    logic [7:0]        Rx_GoodCnt;
    logic [7:0]        Rx_BadCnt;
`endif

    modport master (
        output Rx_Data, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_FrameError,
        output Rx_FCSen, Rx_RdBuff, Rx_Drop,
`ifdef RX_FRAME_FIFO_STATS_EN
        input  Rx_GoodCnt, Rx_BadCnt,
`endif
        input  Rx_DataBuffOut, Rx_Ready, Rx_FrameSize, Rx_Overflow
    );

    modport slave (
        input  Rx_Data, Rx_WrBuff, Rx_EoF, Rx_AbortSignal, Rx_FrameError,
        input  Rx_FCSen, Rx_RdBuff, Rx_Drop,
`ifdef RX_FRAME_FIFO_STATS_EN
        output Rx_GoodCnt, Rx_BadCnt,
`endif
        output Rx_DataBuffOut, Rx_Ready, Rx_FrameSize, Rx_Overflow
    );
endinterface

// File: rtl/rx_frame_fifo.sv
// rtl/rx_frame_fifo.sv - single-frame receive buffer: collect, qualify at EoF, read out or drop
// Optional good/bad frame counters enabled by macro RX_FRAME_FIFO_STATS_EN.
module rx_frame_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 128,
    parameter int SIZE_W = $clog2(DEPTH + 1)
) (
    input logic           Clk,
    input logic           Rst,
    rx_frame_fifo_if.slave bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SIZE_W-1:0] DEPTH_S = SIZE_W'(DEPTH);
    localparam logic [SIZE_W-1:0] ONE     = SIZE_W'(1);
    localparam logic [SIZE_W-1:0] TWO     = SIZE_W'(2);

    typedef enum logic [1:0] {IDLE, RECV, READY} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SIZE_W-1:0] count, count_upd, count_next;
    logic [SIZE_W-1:0] rdptr;
    logic [SIZE_W-1:0] frame_size, good_size;
    logic [DATA_W-1:0] dout;
    logic              overflow;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              ovf_set, ovf_clr;
    logic              frame_good, frame_bad;
    logic              rd_fire, leave_ready;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The byte of a same-cycle write is counted before the EoF verdict is taken.
    always_comb begin
        state_next  = state;
        mem_we      = 1'b0;
        mem_addr    = '0;
        count_upd   = count;
        count_next  = count;
        ovf_set     = 1'b0;
        ovf_clr     = 1'b0;
        frame_good  = 1'b0;
        frame_bad   = 1'b0;
        rd_fire     = 1'b0;
        leave_ready = 1'b0;
        case (state)
            IDLE: begin
                if (bus.Rx_WrBuff) begin
                    mem_we     = 1'b1;
                    count_next = ONE;
                    ovf_clr    = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (bus.Rx_WrBuff) begin
                    if (count < DEPTH_S) begin
                        mem_we    = 1'b1;
                        mem_addr  = count[ADDR_W-1:0];
                        count_upd = count + ONE;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                count_next = count_upd;
                if (bus.Rx_EoF) begin
                    if (bus.Rx_AbortSignal || bus.Rx_FrameError ||
                        (bus.Rx_FCSen && (count_upd <= TWO))) begin
                        frame_bad  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_good = 1'b1;
                        state_next = READY;
                    end
                end
            end
            READY: begin
                ovf_set = bus.Rx_WrBuff;
                if (bus.Rx_Drop) begin
                    leave_ready = 1'b1;
                    state_next  = IDLE;
                end else if (bus.Rx_RdBuff) begin
                    rd_fire = 1'b1;
                    if ((rdptr + ONE) == frame_size) begin
                        leave_ready = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.Rx_Ready = (state == READY);
    end

    assign good_size = bus.Rx_FCSen ? (count_upd - TWO) : count_upd;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_addr] <= bus.Rx_Data;
        end
    end

    // frame_size is forced to zero outside READY so the output needs no gating.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count      <= '0;
            rdptr      <= '0;
            frame_size <= '0;
            dout       <= '0;
            overflow   <= 1'b0;
        end else begin
            count <= count_next;
            if (frame_good) begin
                rdptr      <= '0;
                frame_size <= good_size;
            end else if (rd_fire) begin
                rdptr <= rdptr + ONE;
            end
            if (leave_ready) begin
                frame_size <= '0;
            end
            if (rd_fire) begin
                dout <= mem[rdptr[ADDR_W-1:0]];
            end
            if (ovf_clr) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.Rx_DataBuffOut = dout;
    assign bus.Rx_FrameSize   = frame_size;
    assign bus.Rx_Overflow    = overflow;

`ifdef RX_FRAME_FIFO_STATS_EN
    logic [7:0] good_cnt, bad_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (frame_good && (good_cnt != 8'hFF)) begin
                good_cnt <= good_cnt + 8'd1;
            end
            if (frame_bad && (bad_cnt != 8'hFF)) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end

    assign bus.Rx_GoodCnt = good_cnt;
    assign bus.Rx_BadCnt  = bad_cnt;
`endif
endmodule

// File: tb/tb_rx_frame_fifo.sv
// tb/tb_rx_frame_fifo.sv - directed self-checking bench for rx_frame_fifo (DEPTH=128)
module tb_rx_frame_fifo;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int SIZE_W = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] rd_val;

    rx_frame_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SIZE_W(SIZE_W)) bus ();

    rx_frame_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SIZE_W(SIZE_W)) dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d, input logic eof);
        bus.Rx_Data   = d;
        bus.Rx_WrBuff = 1'b1;
        bus.Rx_EoF    = eof;
        tick();
        bus.Rx_WrBuff = 1'b0;
        bus.Rx_EoF    = 1'b0;
    endtask

    task automatic end_frame();
        bus.Rx_EoF = 1'b1;
        tick();
        bus.Rx_EoF = 1'b0;
    endtask

    task automatic read_byte(output logic [7:0] d);
        bus.Rx_RdBuff = 1'b1;
        tick();
        bus.Rx_RdBuff = 1'b0;
        d = bus.Rx_DataBuffOut;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.Rx_Data        = '0;
        bus.Rx_WrBuff      = 1'b0;
        bus.Rx_EoF         = 1'b0;
        bus.Rx_AbortSignal = 1'b0;
        bus.Rx_FrameError  = 1'b0;
        bus.Rx_FCSen       = 1'b0;
        bus.Rx_RdBuff      = 1'b0;
        bus.Rx_Drop        = 1'b0;
        repeat (3) tick();
        check("rst_ready", {31'd0, bus.Rx_Ready}, 32'd0);
        check("rst_size", {24'd0, bus.Rx_FrameSize}, 32'd0);
        check("rst_ovf", {31'd0, bus.Rx_Overflow}, 32'd0);
        check("rst_dout", {24'd0, bus.Rx_DataBuffOut}, 32'd0);
        rst_n = 1'b1;
        tick();

        // five-byte frame, no FCS strip, EoF on its own cycle
        for (int i = 1; i <= 5; i++) write_byte(8'(i * 8'h11), 1'b0);
        check("f1_ready_before_eof", {31'd0, bus.Rx_Ready}, 32'd0);
        end_frame();
        check("f1_ready", {31'd0, bus.Rx_Ready}, 32'd1);
        check("f1_size", {24'd0, bus.Rx_FrameSize}, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            read_byte(rd_val);
            check($sformatf("f1_rd%0d", i), {24'd0, rd_val}, 32'(i * 8'h11));
        end
        check("f1_ready_after", {31'd0, bus.Rx_Ready}, 32'd0);
        check("f1_size_after", {24'd0, bus.Rx_FrameSize}, 32'd0);

        // same frame with FCS strip, EoF together with the last write
        bus.Rx_FCSen = 1'b1;
        for (int i = 1; i <= 5; i++) write_byte(8'(i * 8'h11), i == 5);
        check("f2_ready", {31'd0, bus.Rx_Ready}, 32'd1);
        check("f2_size", {24'd0, bus.Rx_FrameSize}, 32'd3);
        for (int i = 1; i <= 3; i++) begin
            read_byte(rd_val);
            check($sformatf("f2_rd%0d", i), {24'd0, rd_val}, 32'(i * 8'h11));
        end
        check("f2_ready_after", {31'd0, bus.Rx_Ready}, 32'd0);
        bus.Rx_FCSen = 1'b0;

        read_byte(rd_val);
        check("idle_read_ignored", {24'd0, rd_val}, 32'h33);

        // overflow: 130 writes into 128 words
        for (int i = 0; i < 130; i++) write_byte(8'(i), 1'b0);
        end_frame();
        check("ovf_ready", {31'd0, bus.Rx_Ready}, 32'd1);
        check("ovf_size", {24'd0, bus.Rx_FrameSize}, 32'd128);
        check("ovf_flag", {31'd0, bus.Rx_Overflow}, 32'd1);
        write_byte(8'hEE, 1'b0);
        check("ready_wr_size", {24'd0, bus.Rx_FrameSize}, 32'd128);
        check("ready_wr_ovf", {31'd0, bus.Rx_Overflow}, 32'd1);
        read_byte(rd_val);
        check("ovf_rd0", {24'd0, rd_val}, 32'h00);
        read_byte(rd_val);
        check("ovf_rd1", {24'd0, rd_val}, 32'h01);

        // drop beats read in the same cycle
        bus.Rx_Drop   = 1'b1;
        bus.Rx_RdBuff = 1'b1;
        tick();
        bus.Rx_Drop   = 1'b0;
        bus.Rx_RdBuff = 1'b0;
        check("drop_ready", {31'd0, bus.Rx_Ready}, 32'd0);
        check("drop_dout", {24'd0, bus.Rx_DataBuffOut}, 32'h01);
        check("drop_size", {24'd0, bus.Rx_FrameSize}, 32'd0);
        check("drop_ovf_kept", {31'd0, bus.Rx_Overflow}, 32'd1);

        // next frame clears overflow; abort at EoF discards it
        write_byte(8'hA0, 1'b0);
        check("ovf_cleared", {31'd0, bus.Rx_Overflow}, 32'd0);
        write_byte(8'hA1, 1'b0);
        bus.Rx_AbortSignal = 1'b1;
        end_frame();
        bus.Rx_AbortSignal = 1'b0;
        check("abort_ready", {31'd0, bus.Rx_Ready}, 32'd0);
        check("abort_size", {24'd0, bus.Rx_FrameSize}, 32'd0);
`ifdef RX_FRAME_FIFO_STATS_EN
        check("abort_badcnt", {24'd0, bus.Rx_BadCnt}, 32'd1);
        check("abort_goodcnt", {24'd0, bus.Rx_GoodCnt}, 32'd3);
`endif

        // FCS strip with only two words is discarded
        bus.Rx_FCSen = 1'b1;
        write_byte(8'hB0, 1'b0);
        write_byte(8'hB1, 1'b1);
        bus.Rx_FCSen = 1'b0;
        check("short_fcs_ready", {31'd0, bus.Rx_Ready}, 32'd0);
`ifdef RX_FRAME_FIFO_STATS_EN
        check("short_fcs_badcnt", {24'd0, bus.Rx_BadCnt}, 32'd2);
`endif

        // asynchronous reset mid-frame, then a fresh two-byte frame
        write_byte(8'hDE, 1'b0);
        write_byte(8'hAD, 1'b0);
        write_byte(8'hBE, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, bus.Rx_Ready}, 32'd0);
        check("midrst_dout", {24'd0, bus.Rx_DataBuffOut}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        write_byte(8'h5A, 1'b0);
        write_byte(8'hA5, 1'b1);
        check("postrst_ready", {31'd0, bus.Rx_Ready}, 32'd1);
        check("postrst_size", {24'd0, bus.Rx_FrameSize}, 32'd2);
        read_byte(rd_val);
        check("postrst_rd0", {24'd0, rd_val}, 32'h5A);
        read_byte(rd_val);
        check("postrst_rd1", {24'd0, rd_val}, 32'hA5);
        check("postrst_ready_after", {31'd0, bus.Rx_Ready}, 32'd0);

        // frame error at EoF discards the frame
        write_byte(8'hC0, 1'b0);
        bus.Rx_FrameError = 1'b1;
        write_byte(8'hC1, 1'b1);
        bus.Rx_FrameError = 1'b0;
        check("ferr_ready", {31'd0, bus.Rx_Ready}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
